pipe_mult: RTL and testbench

Parametrised, fully pipelined WIDTH x WIDTH integer multiplier with per-operation signed/unsigned mode. It uses a registered partial-product stage, a registered binary adder tree and valid/ready handshakes with global-stall backpressure. It is the datapath multiply unit for MULT/MULTU in the CPU execute stage and sustains one result per cycle when not stalled.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_add_level.sv | 45 ++++
 rtl/pipe_mult.sv | 120 ++++++++++++
 tb/tb_pipe_mult.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the pipelined multiplier.
// Latency is derived here so the unit and its users agree on it.
package mult_pkg;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mult_mode_e;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One partial-product stage plus one register per adder-tree level.
    function automatic int mult_lat(input int width);
        return 1 + clog2(width);
    endfunction

endpackage

// File: rtl/mult_add_level.sv
// One registered level of the binary adder tree: N_IN terms in, N_IN/2 sums out.
// Sum and sign registers only load on valid beats, so they hold across bubbles.
module mult_add_level
    import mult_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int W2   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   valid_in,
    input  logic                   neg_in,
    input  logic [N_IN*W2-1:0]     terms,
    output logic [(N_IN/2)*W2-1:0] sums,
    output logic                   valid_out,
    output logic                   neg_out
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*W2-1:0] sum_next;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sum_next[i*W2 +: W2] = terms[(2*i)*W2 +: W2] + terms[(2*i+1)*W2 +: W2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sums      <= '0;
            valid_out <= 1'b0;
            neg_out   <= 1'b0;
        end else if (en) begin
            valid_out <= valid_in;
            if (valid_in) begin
                sums    <= sum_next;
                neg_out <= neg_in;
            end
        end
    end

endmodule

// File: rtl/pipe_mult.sv
// Fully pipelined WIDTH x WIDTH multiplier (MULT/MULTU) with valid/ready handshake.
// Sign-magnitude datapath: magnitudes go through the tree, sign is re-applied at the end.
module pipe_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               busy
);

    localparam int LAT    = mult_lat(WIDTH);
    localparam int LEVELS = LAT - 1;
    localparam int W2     = 2 * WIDTH;

    logic                adv;
    mult_mode_e          mode;
    logic                a_neg;
    logic                b_neg;
    logic [WIDTH-1:0]    ma;
    logic [WIDTH-1:0]    mb;
    logic [W2-1:0]       ma_ext;
    logic                pp_neg_next;
    logic [WIDTH*W2-1:0] pp_next;

    logic                pp_valid;
    logic                pp_neg;
    logic [WIDTH*W2-1:0] pp_terms;

    wire  [(WIDTH-1)*W2-1:0] tree;
    wire  [LEVELS-1:0]       lvl_valid;
    wire  [LEVELS-1:0]       lvl_neg;
    logic [W2-1:0]           r;

    // Global stall: everything freezes while the output beat is refused.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign mode     = mult_mode_e'(is_signed);

    always_comb begin
        a_neg       = (mode == MODE_SIGNED) && a[WIDTH-1];
        b_neg       = (mode == MODE_SIGNED) && b[WIDTH-1];
        ma          = a_neg ? -a : a;
        mb          = b_neg ? -b : b;
        ma_ext      = {{WIDTH{1'b0}}, ma};
        pp_neg_next = a_neg ^ b_neg;
        pp_next     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mb[i]) begin
                pp_next[i*W2 +: W2] = ma_ext << i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pp_valid <= 1'b0;
            pp_neg   <= 1'b0;
            pp_terms <= '0;
        end else if (adv) begin
            pp_valid <= in_valid;
            if (in_valid) begin
                pp_terms <= pp_next;
                pp_neg   <= pp_neg_next;
            end
        end
    end

    // Level k reads the previous level's slice of tree and writes its own slice.
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int N_IN    = WIDTH >> k;
        localparam int IN_OFF  = WIDTH - 2 * N_IN;
        localparam int OUT_OFF = WIDTH - N_IN;

        wire [N_IN*W2-1:0] terms;
        wire               v_in;
        wire               n_in;

        if (k == 0) begin : g_first
            assign terms = pp_terms;
            assign v_in  = pp_valid;
            assign n_in  = pp_neg;
        end else begin : g_inner
            assign terms = tree[IN_OFF*W2 +: N_IN*W2];
            assign v_in  = lvl_valid[k-1];
            assign n_in  = lvl_neg[k-1];
        end

        mult_add_level #(
            .N_IN (N_IN),
            .W2   (W2)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .en        (adv),
            .valid_in  (v_in),
            .neg_in    (n_in),
            .terms     (terms),
            .sums      (tree[OUT_OFF*W2 +: (N_IN/2)*W2]),
            .valid_out (lvl_valid[k]),
            .neg_out   (lvl_neg[k])
        );
    end

    // Sign correction rides on the last sum register, so it costs no cycle.
    assign r         = tree[(WIDTH-2)*W2 +: W2];
    assign z         = lvl_neg[LEVELS-1] ? -r : r;
    assign out_valid = lvl_valid[LEVELS-1];
    assign busy      = pp_valid | (|lvl_valid);

endmodule

// File: tb/tb_pipe_mult.sv
// Self-checking bench for pipe_mult: directed literal cases plus a randomized
// scoreboard against a plain-arithmetic product model.
module tb_pipe_mult;

    localparam int LAT32 = 6;
    localparam int LAT8  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] z;
    logic        busy;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        sgn8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [15:0] z8;
    logic        busy8;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_accept_cyc = 0;
    int          lat;
    logic        drv_done;
    logic        exp_v;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_z = '0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_head;
    logic [63:0] lit_signed[4];

    pipe_mult #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    pipe_mult #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .is_signed (sgn8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .z         (z8),
        .busy      (busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: extend to 64 bits by mode, multiply, keep the low 64 bits.
    function automatic logic [63:0] model_product(input logic [31:0] x, input logic [31:0] y,
                                                  input logic s);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{x[31]}}, x} : {32'b0, x};
        ye = s ? {{32{y[31]}}, y} : {32'b0, y};
        return xe * ye;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic failTimeout(input string name, input int waited);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: no DUT response after %0d cycles, expected one within bound",
                 name, waited);
    endtask

    // Presents one beat and returns at posedge+1 just after it was accepted.
    task automatic applyStimulus(input logic [31:0] xa, input logic [31:0] xb, input logic xs);
        int guard;
        guard     = 0;
        a         = xa;
        b         = xb;
        is_signed = xs;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) failTimeout("accept_timeout", guard);
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge where out_valid is first seen high.
    task automatic waitForValid(input string name);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 100);
        if (!out_valid) failTimeout(name, guard);
    endtask

    task automatic drainCheck(input string name);
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard and protocol rules for the 32-bit unit, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            checkOutput("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_hold) begin
                checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_z", z, prev_z);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_product(a, b, is_signed));
                last_accept_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL extra_output: got z=0x%h, expected no output", z);
                end else begin
                    exp_head = exp_q.pop_front();
                    checkOutput("product", z, exp_head);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_z    = z;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time bound, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        lit_signed[0] = 64'hFFFF_FFFF_FFFF_FFF1;
        lit_signed[1] = 64'h0000_0000_0000_0001;
        lit_signed[2] = 64'h4000_0000_0000_0000;
        lit_signed[3] = 64'hC000_0000_8000_0000;

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_z", z, 64'd0);
        checkOutput("reset_out_valid8", 64'(out_valid8), 64'd0);
        checkOutput("reset_busy8", 64'(busy8), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);

        // Unsigned max * max, latency from accept to first valid.
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        in_valid = 1'b0;
        waitForValid("t1_valid_timeout");
        lat = cyc - last_accept_cyc;
        checkOutput("t1_latency", 64'(lat), 64'(LAT32));
        checkOutput("t1_z", z, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk);
        #1;

        // Signed set back-to-back: four consecutive results in order.
        applyStimulus(32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
        applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        in_valid = 1'b0;
        waitForValid("t2_valid_timeout");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("t2_out_valid", 64'(out_valid), 64'd1);
            checkOutput("t2_z", z, lit_signed[i]);
        end
        @(posedge clk);
        #1;

        // Same operands, signed then unsigned.
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        in_valid = 1'b0;
        waitForValid("t3_valid_timeout");
        checkOutput("t3_signed_z", z, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        checkOutput("t3_unsigned_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_unsigned_z", z, 64'h0000_0001_FFFF_FFFE);
        @(posedge clk);
        #1;

        // Backpressure: 10 streamed beats, 3-cycle hold after the first output.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    applyStimulus($urandom, $urandom, 1'($urandom_range(1)));
                end
                in_valid = 1'b0;
            end
            begin
                waitForValid("t4_valid_timeout");
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput("t4_hold_in_ready", 64'(in_ready), 64'd0);
                    checkOutput("t4_hold_out_valid", 64'(out_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drainCheck("t4_drain");

        // Reset mid-flight discards everything in the pipe.
        applyStimulus(32'h0000_1234, 32'h0000_5678, 1'b0);
        applyStimulus(32'hFFFF_FF00, 32'h0000_0011, 1'b1);
        applyStimulus(32'hDEAD_BEEF, 32'h0000_0003, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("t5_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t5_busy", 64'(busy), 64'd0);
        checkOutput("t5_z", z, 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t5_quiet_out_valid", 64'(out_valid), 64'd0);
            checkOutput("t5_in_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;

        // WIDTH=8 unit: alternating beats, signed 0x80 * 0x80.
        a8   = 8'h80;
        b8   = 8'h80;
        sgn8 = 1'b1;
        for (int r = 0; r < 12; r++) begin
            in_valid8 = (r < 5) && (r % 2 == 0);
            @(negedge clk);
            if (in_valid8) checkOutput("w8_in_ready", 64'(in_ready8), 64'd1);
            exp_v = (r >= LAT8) && (r <= LAT8 + 4) && ((r - LAT8) % 2 == 0);
            checkOutput("w8_out_valid", 64'(out_valid8), 64'(exp_v));
            if (exp_v) checkOutput("w8_z", 64'(z8), 64'h4000);
            @(posedge clk);
            #1;
        end
        in_valid8 = 1'b0;

        // Randomized traffic with random gaps and random backpressure.
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(2)) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(pick_operand(), pick_operand(), 1'($urandom_range(1)));
                end
                in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drainCheck("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
